// File: rtl/cbi_audio_core.sv
// Register-mapped multi-channel audio sample core: per-channel TX/RX FIFOs, status/IRQ and config.
// Define CBI_SIGN_EXT_EN to sign-extend DIN reads; the default build zero-extends them.
module cbi_audio_core #(
    parameter int unsigned NCH        = 2,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned SW         = 24,
    parameter int unsigned AW         = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              interrupt,
    input  logic [AW-1:0]     wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              wr_en,
    output logic              wr_err,
    input  logic [AW-1:0]     rd_addr,
    output logic [31:0]       rd_data,
    input  logic              rd_valid_in,
    output logic              rd_valid_out,
    output logic              rxen,
    output logic              txen,
    output logic [2:0]        cfg_mclk_rate,
    output logic              cfg_rjust,
    output logic              cfg_lsb_first,
    input  logic [NCH-1:0]    smp_tx_req,
    output logic [NCH*SW-1:0] smp_tx_data,
    input  logic [NCH-1:0]    smp_rx_vld,
    input  logic [NCH*SW-1:0] smp_rx_data
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;
    localparam int unsigned FW    = 6 * NCH;

    localparam logic [31:0]   CVR_VALUE = 32'hcb19_9820;
    localparam logic [AW-1:0] ADDR_CVR  = AW'(0);
    localparam logic [AW-1:0] ADDR_SR   = AW'(1);
    localparam logic [AW-1:0] ADDR_CR   = AW'(2);
    localparam logic [AW-1:0] ADDR_LCFR = AW'(3);

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [LW-1:0]         lvl_t;

    ptr_t          tx_head_q  [NCH];
    ptr_t          tx_tail_q  [NCH];
    lvl_t          tx_level_q [NCH];
    ptr_t          rx_head_q  [NCH];
    ptr_t          rx_tail_q  [NCH];
    lvl_t          rx_level_q [NCH];
    logic [SW-1:0] tx_mem     [NCH][DEPTH];
    logic [SW-1:0] rx_mem     [NCH][DEPTH];

    logic [NCH-1:0]    tx_full, tx_empty, rx_full, rx_empty;
    logic [NCH-1:0]    tx_push, tx_pop, rx_push, rx_pop;
    logic [NCH-1:0]    tx_unf_set, rx_ovf_set;
    logic [NCH-1:0]    wr_dout, rd_din;
    logic [NCH-1:0]    tx_unf_q, rx_ovf_q;
    logic              cr_rxen_q, cr_txen_q;
    logic [FW-1:0]     cr_ie_q;
    logic [31:0]       lcfr_q;
    logic [31:0]       rd_data_q;
    logic              rd_valid_q;
    logic [NCH*SW-1:0] tx_data_q;

    logic              cr_wr, soft_rst, flag_clr;
    logic [FW-1:0]     sr_bits;
    logic [31:0]       rd_word;
    logic [SW-1:0]     din_word;

    always_comb begin
        cr_wr    = wr_en && (wr_addr == ADDR_CR);
        soft_rst = cr_wr && wr_data[31];
        flag_clr = cr_wr && wr_data[30];
        for (int k = 0; k < NCH; k++) begin
            wr_dout[k] = wr_en && (wr_addr == AW'(4 + 2 * k));
            rd_din[k]  = (rd_addr == AW'(5 + 2 * k));
        end
    end

    // A push into a full FIFO is accepted when a pop frees a slot in the same cycle.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            tx_full[k]    = (tx_level_q[k] == lvl_t'(DEPTH));
            tx_empty[k]   = (tx_level_q[k] == '0);
            rx_full[k]    = (rx_level_q[k] == lvl_t'(DEPTH));
            rx_empty[k]   = (rx_level_q[k] == '0);
            tx_pop[k]     = cr_txen_q && smp_tx_req[k] && !tx_empty[k];
            tx_unf_set[k] = cr_txen_q && smp_tx_req[k] && tx_empty[k];
            tx_push[k]    = wr_dout[k] && (!tx_full[k] || tx_pop[k]);
            rx_pop[k]     = rd_valid_in && rd_din[k] && !rx_empty[k];
            rx_push[k]    = cr_rxen_q && smp_rx_vld[k] && (!rx_full[k] || rx_pop[k]);
            rx_ovf_set[k] = cr_rxen_q && smp_rx_vld[k] && rx_full[k] && !rx_pop[k];
        end
    end

    always_comb begin
        wr_err = 1'b0;
        if (wr_en) begin
            wr_err = 1'b1;
            if ((wr_addr == ADDR_CR) || (wr_addr == ADDR_LCFR)) begin
                wr_err = 1'b0;
            end
            for (int k = 0; k < NCH; k++) begin
                if (wr_dout[k]) begin
                    wr_err = tx_full[k] && !tx_pop[k];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            sr_bits[6*k +: 6] = {rx_ovf_q[k], tx_unf_q[k], !rx_empty[k], rx_full[k],
                                 !tx_full[k], tx_empty[k]};
        end
    end

    assign interrupt = |(sr_bits & cr_ie_q);

    always_comb begin
        rd_word  = '0;
        din_word = '0;
        case (rd_addr)
            ADDR_CVR:  rd_word = CVR_VALUE;
            ADDR_SR:   rd_word = 32'(sr_bits);
            ADDR_CR: begin
                rd_word[29]     = cr_rxen_q;
                rd_word[28]     = cr_txen_q;
                rd_word[FW-1:0] = cr_ie_q;
            end
            ADDR_LCFR: rd_word = lcfr_q;
            default:   rd_word = '0;
        endcase
        for (int k = 0; k < NCH; k++) begin
            if (rd_din[k] && !rx_empty[k]) begin
                din_word = rx_mem[k][rx_tail_q[k]];
`ifdef CBI_SIGN_EXT_EN
                rd_word  = 32'($signed(din_word));
`else
                rd_word  = 32'(din_word);
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                tx_head_q[k]  <= '0;
                tx_tail_q[k]  <= '0;
                tx_level_q[k] <= '0;
                rx_head_q[k]  <= '0;
                rx_tail_q[k]  <= '0;
                rx_level_q[k] <= '0;
            end
            tx_unf_q  <= '0;
            rx_ovf_q  <= '0;
            cr_rxen_q <= 1'b0;
            cr_txen_q <= 1'b0;
            cr_ie_q   <= '0;
            lcfr_q    <= '0;
            tx_data_q <= '0;
            rd_data_q <= '0;
        end else if (soft_rst) begin
            // Soft reset discards every other event and field of this cycle.
            for (int k = 0; k < NCH; k++) begin
                tx_head_q[k]  <= '0;
                tx_tail_q[k]  <= '0;
                tx_level_q[k] <= '0;
                rx_head_q[k]  <= '0;
                rx_tail_q[k]  <= '0;
                rx_level_q[k] <= '0;
            end
            tx_unf_q  <= '0;
            rx_ovf_q  <= '0;
            cr_rxen_q <= 1'b0;
            cr_txen_q <= 1'b0;
            cr_ie_q   <= '0;
            lcfr_q    <= '0;
            tx_data_q <= '0;
            rd_data_q <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (tx_push[k]) tx_head_q[k] <= tx_head_q[k] + 1'b1;
                if (tx_pop[k])  tx_tail_q[k] <= tx_tail_q[k] + 1'b1;
                if (rx_push[k]) rx_head_q[k] <= rx_head_q[k] + 1'b1;
                if (rx_pop[k])  rx_tail_q[k] <= rx_tail_q[k] + 1'b1;
                case ({tx_push[k], tx_pop[k]})
                    2'b10:   tx_level_q[k] <= tx_level_q[k] + 1'b1;
                    2'b01:   tx_level_q[k] <= tx_level_q[k] - 1'b1;
                    default: tx_level_q[k] <= tx_level_q[k];
                endcase
                case ({rx_push[k], rx_pop[k]})
                    2'b10:   rx_level_q[k] <= rx_level_q[k] + 1'b1;
                    2'b01:   rx_level_q[k] <= rx_level_q[k] - 1'b1;
                    default: rx_level_q[k] <= rx_level_q[k];
                endcase
                if (smp_tx_req[k]) begin
                    tx_data_q[k*SW +: SW] <= tx_pop[k] ? tx_mem[k][tx_tail_q[k]] : '0;
                end
            end
            // A flag event in the same cycle as the clear keeps the flag set.
            tx_unf_q <= (tx_unf_q & ~{NCH{flag_clr}}) | tx_unf_set;
            rx_ovf_q <= (rx_ovf_q & ~{NCH{flag_clr}}) | rx_ovf_set;
            if (cr_wr) begin
                cr_rxen_q <= wr_data[29];
                cr_txen_q <= wr_data[28];
                cr_ie_q   <= wr_data[FW-1:0];
            end
            if (wr_en && (wr_addr == ADDR_LCFR)) begin
                lcfr_q <= wr_data;
            end
            rd_data_q <= rd_word;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (tx_push[k]) tx_mem[k][tx_head_q[k]] <= wr_data[SW-1:0];
            if (rx_push[k]) rx_mem[k][rx_head_q[k]] <= smp_rx_data[k*SW +: SW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_in;
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_valid_out  = rd_valid_q;
    assign rxen          = cr_rxen_q;
    assign txen          = cr_txen_q;
    assign cfg_mclk_rate = lcfr_q[26:24];
    assign cfg_rjust     = lcfr_q[1];
    assign cfg_lsb_first = lcfr_q[0];
    assign smp_tx_data   = tx_data_q;

endmodule

// File: tb/tb_cbi_audio_core.sv
// Scoreboard bench for cbi_audio_core: stimulus queues expected read/sample data, a negedge
// monitor pops and compares whenever rd_valid_out or a delayed smp_tx_req shows an output.
module tb_cbi_audio_core;

    localparam int NCH = 2;
    localparam int DL  = 4;
    localparam int SW  = 24;
    localparam int AW  = 4;

`ifdef CBI_SIGN_EXT_EN
    localparam logic [31:0] SX_EXP = 32'hff80_0001;
`else
    localparam logic [31:0] SX_EXP = 32'h0080_0001;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              interrupt;
    logic [AW-1:0]     wr_addr;
    logic [31:0]       wr_data;
    logic              wr_en;
    logic              wr_err;
    logic [AW-1:0]     rd_addr;
    logic [31:0]       rd_data;
    logic              rd_valid_in;
    logic              rd_valid_out;
    logic              rxen, txen;
    logic [2:0]        cfg_mclk_rate;
    logic              cfg_rjust, cfg_lsb_first;
    logic [NCH-1:0]    smp_tx_req;
    logic [NCH*SW-1:0] smp_tx_data;
    logic [NCH-1:0]    smp_rx_vld;
    logic [NCH*SW-1:0] smp_rx_data;

    int total = 0;
    int bad   = 0;

    logic [31:0]    rd_exp_q[$];
    string          rd_name_q[$];
    logic [SW-1:0]  tx_exp_q[$];
    int             tx_ch_q[$];
    logic [NCH-1:0] tx_req_d;
    logic [SW-1:0]  mon_e;
    int             mon_c;
    string          mon_n;

    cbi_audio_core #(.NCH(NCH), .DEPTH_LOG2(DL), .SW(SW), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .interrupt    (interrupt),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .wr_err       (wr_err),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid_in  (rd_valid_in),
        .rd_valid_out (rd_valid_out),
        .rxen         (rxen),
        .txen         (txen),
        .cfg_mclk_rate(cfg_mclk_rate),
        .cfg_rjust    (cfg_rjust),
        .cfg_lsb_first(cfg_lsb_first),
        .smp_tx_req   (smp_tx_req),
        .smp_tx_data  (smp_tx_data),
        .smp_rx_vld   (smp_rx_vld),
        .smp_rx_data  (smp_rx_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    always @(posedge clk) tx_req_d <= smp_tx_req;

    always @(negedge clk) begin
        if (rd_valid_out) begin
            if (rd_exp_q.size() == 0) begin
                check("rd_unexpected", {31'b0, rd_valid_out}, 32'h0);
            end else begin
                mon_n = rd_name_q.pop_front();
                check(mon_n, rd_data, rd_exp_q.pop_front());
            end
        end
        for (int ch = 0; ch < NCH; ch++) begin
            if (tx_req_d[ch]) begin
                if (tx_exp_q.size() == 0) begin
                    check("tx_unexpected", 32'(tx_req_d), 32'h0);
                end else begin
                    mon_e = tx_exp_q.pop_front();
                    mon_c = tx_ch_q.pop_front();
                    check("tx_data", 32'(smp_tx_data[mon_c*SW +: SW]), 32'(mon_e));
                end
            end
        end
    end

    task automatic host_write(input int a, input logic [31:0] d, input logic exp_err);
        wr_addr = AW'(a);
        wr_data = d;
        wr_en   = 1'b1;
        #1;
        check("wr_err", {31'b0, wr_err}, {31'b0, exp_err});
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic host_read(input int a, input logic [31:0] exp, input string name);
        rd_addr     = AW'(a);
        rd_valid_in = 1'b1;
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        @(posedge clk); #1;
        rd_valid_in = 1'b0;
    endtask

    task automatic rx_sample(input int ch, input logic [SW-1:0] d);
        smp_rx_vld[ch]            = 1'b1;
        smp_rx_data[ch*SW +: SW]  = d;
        @(posedge clk); #1;
        smp_rx_vld[ch] = 1'b0;
    endtask

    task automatic tx_pulse(input int ch, input logic [SW-1:0] exp);
        smp_tx_req[ch] = 1'b1;
        tx_exp_q.push_back(exp);
        tx_ch_q.push_back(ch);
        @(posedge clk); #1;
        smp_tx_req[ch] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wr_addr = '0; wr_data = '0; wr_en = 1'b0;
        rd_addr = '0; rd_valid_in = 1'b0;
        smp_tx_req = '0; smp_rx_vld = '0; smp_rx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_irq", {31'b0, interrupt}, 32'h0);
        check("rst_rd_valid", {31'b0, rd_valid_out}, 32'h0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_tx_data", 32'(smp_tx_data[SW-1:0]) | 32'(smp_tx_data[2*SW-1:SW]), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        host_read(0, 32'hcb19_9820, "cvr");
        host_read(1, 32'h0000_00c3, "sr_reset");

        // TX fill, overflow-drop, drain and underflow
        host_write(2, 32'h1000_0000, 1'b0);
        for (int i = 0; i < 16; i++) host_write(4, 32'h00a0_0000 + i, 1'b0);
        host_read(1, 32'h0000_00c0, "sr_tx_full");
        host_write(4, 32'h00a0_0010, 1'b1);
        host_read(1, 32'h0000_00c0, "sr_tx_still_full");
        for (int i = 0; i < 16; i++) tx_pulse(0, 24'ha00000 + 24'(i));
        tx_pulse(0, 24'h0);
        host_read(1, 32'h0000_00d3, "sr_tx_unf");

        // Clear flags, enable RX, ie on rx_ovf ch0
        host_write(2, 32'h6000_0020, 1'b0);
        host_read(1, 32'h0000_00c3, "sr_after_clr");
        check("irq_after_clr", {31'b0, interrupt}, 32'h0);

        for (int i = 1; i <= 16; i++) rx_sample(0, SW'(i));
        host_read(1, 32'h0000_00cf, "sr_rx_full");
        check("irq_rx_full", {31'b0, interrupt}, 32'h0);

        // Push and pop together while full
        smp_rx_vld[0]        = 1'b1;
        smp_rx_data[SW-1:0]  = 24'd17;
        rd_addr              = AW'(5);
        rd_valid_in          = 1'b1;
        rd_exp_q.push_back(32'd1);
        rd_name_q.push_back("din_simul");
        @(posedge clk); #1;
        smp_rx_vld[0] = 1'b0;
        rd_valid_in   = 1'b0;
        host_read(1, 32'h0000_00cf, "sr_simul");

        rx_sample(0, 24'd18);
        host_read(1, 32'h0000_00ef, "sr_rx_ovf");
        check("irq_ovf", {31'b0, interrupt}, 32'h1);
        for (int i = 2; i <= 17; i++) host_read(5, 32'(i), "din_drain");
        host_read(5, 32'h0, "din_empty");
        host_read(1, 32'h0000_00e3, "sr_rx_empty_ovf");
        host_write(2, 32'h6000_0020, 1'b0);
        check("irq_cleared", {31'b0, interrupt}, 32'h0);
        host_read(1, 32'h0000_00c3, "sr_ovf_cleared");
        host_read(2, 32'h2000_0020, "cr_readback");

        rx_sample(0, 24'h800001);
        host_read(5, SX_EXP, "din_sign");

        host_write(3, 32'h0700_0003, 1'b0);
        check("cfg_out", 32'({cfg_mclk_rate, cfg_rjust, cfg_lsb_first}), 32'h1f);
        host_read(3, 32'h0700_0003, "lcfr_readback");

        host_write(0, 32'h1234_5678, 1'b1);
        host_write(1, 32'h1234_5678, 1'b1);
        host_write(5, 32'h1234_5678, 1'b1);
        host_write(7, 32'h1234_5678, 1'b1);
        host_write(15, 32'h1234_5678, 1'b1);
        host_read(0, 32'hcb19_9820, "cvr_after_bad_wr");

        // Soft reset with data in flight
        for (int i = 0; i < 3; i++) host_write(4, 32'h0011_1111, 1'b0);
        for (int i = 0; i < 2; i++) host_write(6, 32'h0022_2222, 1'b0);
        for (int i = 0; i < 2; i++) rx_sample(1, 24'h333333);
        host_read(1, 32'h0000_0282, "sr_before_srst");
        host_write(2, 32'h8000_0000, 1'b0);
        host_read(1, 32'h0000_00c3, "sr_after_srst");
        host_read(2, 32'h0, "cr_after_srst");
        host_read(3, 32'h0, "lcfr_after_srst");
        check("cfg_after_srst", 32'({cfg_mclk_rate, cfg_rjust, cfg_lsb_first, rxen, txen}), 32'h0);
        host_write(2, 32'h1000_0000, 1'b0);
        host_write(4, 32'h00ab_cdef, 1'b0);
        tx_pulse(0, 24'habcdef);
        host_read(2, 32'h1000_0000, "cr_second_wr");
        host_read(1, 32'h0000_00c3, "sr_final");

        for (int i = 0; i < 20 && (rd_exp_q.size() != 0 || tx_exp_q.size() != 0); i++) begin
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        check("rd_drain", 32'(rd_exp_q.size()), 32'h0);
        check("tx_drain", 32'(tx_exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
